// File: rtl/cr16_button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability-count debounce FSM and
// optional hold-to-auto-repeat step generator.
// Ports:
//   I_CLK      system clock
//   I_RST      synchronous active-low reset
//   I_BUTTON   raw asynchronous button level
//   O_LEVEL    debounced pressed level (1 = pressed)
//   O_PRESS    one-cycle pulse on accepted press
//   O_RELEASE  one-cycle pulse on accepted release
//   O_STEP     one-cycle pulse on accepted press and on every auto-repeat
module cr16_button_debounce #(
    parameter int unsigned P_DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned P_ACTIVE_LOW      = 1,
    parameter int unsigned P_REPEAT_DELAY    = 0,
    parameter int unsigned P_REPEAT_PERIOD   = 1
) (
    input  logic I_CLK,
    input  logic I_RST,
    input  logic I_BUTTON,
    output logic O_LEVEL,
    output logic O_PRESS,
    output logic O_RELEASE,
    output logic O_STEP
);

    localparam int unsigned MAX_DR = (P_DEBOUNCE_CYCLES > P_REPEAT_DELAY) ?
                                     P_DEBOUNCE_CYCLES : P_REPEAT_DELAY;
    localparam int unsigned MAX_ALL = (MAX_DR > P_REPEAT_PERIOD) ? MAX_DR : P_REPEAT_PERIOD;
    localparam int unsigned CW_RAW  = $clog2(MAX_ALL + 1);
    localparam int unsigned CW      = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic          REL_LVL  = (P_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] DEB_LAST = CW'(P_DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] REP_DLY  = CW'(P_REPEAT_DELAY);
    localparam logic [CW-1:0] REP_PER  = CW'(P_REPEAT_PERIOD);
    localparam bit            ONE_SHOT = (P_DEBOUNCE_CYCLES == 1);
    localparam bit            REP_EN   = (P_REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state;
    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] rcnt;
    logic          repeated;

    // Normalized synchronized level: 1 = pressed regardless of button polarity.
    logic          pressed_c;
    logic [CW-1:0] rcnt_inc_c;

    assign pressed_c  = sync_q2 ^ REL_LVL;
    assign rcnt_inc_c = rcnt + CW'(1);

    // Synchronizer, debounce FSM and repeat generator; all outputs registered.
    always_ff @(posedge I_CLK) begin
        if (!I_RST) begin
            sync_q1   <= REL_LVL;
            sync_q2   <= REL_LVL;
            state     <= IDLE;
            dcnt      <= '0;
            rcnt      <= '0;
            repeated  <= 1'b0;
            O_LEVEL   <= 1'b0;
            O_PRESS   <= 1'b0;
            O_RELEASE <= 1'b0;
            O_STEP    <= 1'b0;
        end else begin
            sync_q1   <= I_BUTTON;
            sync_q2   <= sync_q1;
            O_PRESS   <= 1'b0;
            O_RELEASE <= 1'b0;
            O_STEP    <= 1'b0;

            case (state)
                IDLE: begin
                    if (pressed_c) begin
                        if (ONE_SHOT) begin
                            state    <= HELD;
                            dcnt     <= '0;
                            rcnt     <= '0;
                            repeated <= 1'b0;
                            O_LEVEL  <= 1'b1;
                            O_PRESS  <= 1'b1;
                            O_STEP   <= 1'b1;
                        end else begin
                            state <= PRESS_WAIT;
                            dcnt  <= CW'(1);
                        end
                    end
                end

                PRESS_WAIT: begin
                    if (!pressed_c) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == DEB_LAST) begin
                        state    <= HELD;
                        dcnt     <= '0;
                        rcnt     <= '0;
                        repeated <= 1'b0;
                        O_LEVEL  <= 1'b1;
                        O_PRESS  <= 1'b1;
                        O_STEP   <= 1'b1;
                    end else begin
                        dcnt <= dcnt + CW'(1);
                    end
                end

                HELD: begin
                    if (!pressed_c) begin
                        if (ONE_SHOT) begin
                            state     <= IDLE;
                            dcnt      <= '0;
                            O_LEVEL   <= 1'b0;
                            O_RELEASE <= 1'b1;
                        end else begin
                            state <= RELEASE_WAIT;
                            dcnt  <= CW'(1);
                        end
                    end else if (REP_EN) begin
                        // First repeat after REP_DLY held cycles, then every REP_PER.
                        if (!repeated && (rcnt_inc_c == REP_DLY)) begin
                            O_STEP   <= 1'b1;
                            rcnt     <= '0;
                            repeated <= 1'b1;
                        end else if (repeated && (rcnt_inc_c == REP_PER)) begin
                            O_STEP <= 1'b1;
                            rcnt   <= '0;
                        end else begin
                            rcnt <= rcnt_inc_c;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    // rcnt is left untouched so a release glitch does not restart repeat timing.
                    if (pressed_c) begin
                        state <= HELD;
                        dcnt  <= '0;
                    end else if (dcnt == DEB_LAST) begin
                        state     <= IDLE;
                        dcnt      <= '0;
                        O_LEVEL   <= 1'b0;
                        O_RELEASE <= 1'b1;
                    end else begin
                        dcnt <= dcnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    dcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr16_button_debounce.sv
// Bench for cr16_button_debounce: three configurations side by side, directed
// scenarios plus randomized stimulus against a run-length reference model.
module tb_cr16_button_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn;

    always #5 clk = ~clk;

    // Per-configuration parameters: dut0 plain, dut1 auto-repeat, dut2 N=1 active-high.
    int m_n  [3] = '{4, 4, 1};
    int m_al [3] = '{1, 1, 0};
    int m_d  [3] = '{0, 10, 0};
    int m_p  [3] = '{1, 3, 1};

    logic lvl0, prs0, rel0, stp0;
    logic lvl1, prs1, rel1, stp1;
    logic lvl2, prs2, rel2, stp2;
    logic [3:0] act [3];

    assign act[0] = {lvl0, prs0, rel0, stp0};
    assign act[1] = {lvl1, prs1, rel1, stp1};
    assign act[2] = {lvl2, prs2, rel2, stp2};

    cr16_button_debounce #(.P_DEBOUNCE_CYCLES(4), .P_ACTIVE_LOW(1),
                           .P_REPEAT_DELAY(0), .P_REPEAT_PERIOD(1)) u_dut0 (
        .I_CLK(clk), .I_RST(rst_n), .I_BUTTON(btn[0]),
        .O_LEVEL(lvl0), .O_PRESS(prs0), .O_RELEASE(rel0), .O_STEP(stp0));

    cr16_button_debounce #(.P_DEBOUNCE_CYCLES(4), .P_ACTIVE_LOW(1),
                           .P_REPEAT_DELAY(10), .P_REPEAT_PERIOD(3)) u_dut1 (
        .I_CLK(clk), .I_RST(rst_n), .I_BUTTON(btn[1]),
        .O_LEVEL(lvl1), .O_PRESS(prs1), .O_RELEASE(rel1), .O_STEP(stp1));

    cr16_button_debounce #(.P_DEBOUNCE_CYCLES(1), .P_ACTIVE_LOW(0),
                           .P_REPEAT_DELAY(0), .P_REPEAT_PERIOD(1)) u_dut2 (
        .I_CLK(clk), .I_RST(rst_n), .I_BUTTON(btn[2]),
        .O_LEVEL(lvl2), .O_PRESS(prs2), .O_RELEASE(rel2), .O_STEP(stp2));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a 2-deep delay line of pressed samples, the accepted level,
    // the length of the current run of samples disagreeing with it, and the number
    // of pressed samples seen while steadily held (drives the repeat schedule).
    bit         dl0  [3];
    bit         dl1  [3];
    bit         m_lvl[3];
    int         run  [3];
    int         hold [3];
    logic [3:0] expv [3];

    always @(posedge clk) begin
        bit obs, nv, pr, rl, st;
        for (int i = 0; i < 3; i++) begin
            nv = (m_al[i] != 0) ? !btn[i] : btn[i];
            if (!rst_n) begin
                dl0[i] = 1'b0; dl1[i] = 1'b0; m_lvl[i] = 1'b0;
                run[i] = 0; hold[i] = 0; expv[i] = 4'b0000;
            end else begin
                obs = dl0[i]; dl0[i] = dl1[i]; dl1[i] = nv;
                pr = 1'b0; rl = 1'b0; st = 1'b0;
                if (obs != m_lvl[i]) begin
                    run[i]++;
                    if (run[i] >= m_n[i]) begin
                        m_lvl[i] = obs;
                        run[i] = 0;
                        if (obs) begin pr = 1'b1; st = 1'b1; hold[i] = 0; end
                        else rl = 1'b1;
                    end
                end else begin
                    if (m_lvl[i] && run[i] == 0) begin
                        hold[i]++;
                        if (m_d[i] > 0 && (hold[i] == m_d[i] ||
                            (hold[i] > m_d[i] && (hold[i] - m_d[i]) % m_p[i] == 0)))
                            st = 1'b1;
                    end
                    run[i] = 0;
                end
                expv[i] = {m_lvl[i], pr, rl, st};
            end
        end
    end

    task automatic set_btn(input int i, input bit pressed);
        btn[i] = (m_al[i] != 0) ? !pressed : pressed;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn   = 3'b011;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (act[i] !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %b want 0000", i, act[i]);
            end
        end
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (act[i] !== expv[i]) begin
                    n_bad++;
                    $display("FAIL reset_idle dut%0d cyc%0d: got %b want %b", i, j, act[i], expv[i]);
                end
            end
        end
    endtask

    task automatic test_clean_press;
        int at = -1, pcnt = 0, rcnt = 0;
        set_btn(0, 1'b1);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            n_cmp++;
            if (act[0] !== expv[0]) begin
                n_bad++;
                $display("FAIL clean_press cyc%0d: got %b want %b", j, act[0], expv[0]);
            end
            if (act[0][2]) begin pcnt++; if (at < 0) at = j; end
            if (act[0][1]) rcnt++;
        end
        n_cmp++;
        if (at != 5 || pcnt != 1 || rcnt != 0) begin
            n_bad++;
            $display("FAIL clean_press_timing: press at %0d x%0d rel x%0d, want at 5 x1 rel x0", at, pcnt, rcnt);
        end
    endtask

    task automatic test_bounce;
        int at = -1, pcnt = 0;
        set_btn(0, 1'b0);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            n_cmp++;
            if (act[0] !== expv[0]) begin
                n_bad++;
                $display("FAIL bounce_release cyc%0d: got %b want %b", j, act[0], expv[0]);
            end
        end
        for (int b = 0; b < 4; b++) begin
            set_btn(0, (b % 2) == 0);
            @(negedge clk);
            n_cmp++;
            if (act[0] !== expv[0]) begin
                n_bad++;
                $display("FAIL bounce cyc%0d: got %b want %b", b, act[0], expv[0]);
            end
            if (act[0][2]) pcnt++;
        end
        set_btn(0, 1'b1);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            n_cmp++;
            if (act[0] !== expv[0]) begin
                n_bad++;
                $display("FAIL bounce_settle cyc%0d: got %b want %b", j, act[0], expv[0]);
            end
            if (act[0][2]) begin pcnt++; if (at < 0) at = j; end
        end
        n_cmp++;
        if (at != 5 || pcnt != 1) begin
            n_bad++;
            $display("FAIL bounce_timing: press at %0d x%0d, want at 5 x1", at, pcnt);
        end
    endtask

    task automatic test_release_glitch;
        int at = -1, rcnt = 0, drops = 0;
        bit pat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int g = 0; g < 4; g++) begin
            set_btn(0, pat[g]);
            @(negedge clk);
            n_cmp++;
            if (act[0] !== expv[0]) begin
                n_bad++;
                $display("FAIL glitch cyc%0d: got %b want %b", g, act[0], expv[0]);
            end
            if (!act[0][3]) drops++;
            if (act[0][1]) rcnt++;
        end
        set_btn(0, 1'b0);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            n_cmp++;
            if (act[0] !== expv[0]) begin
                n_bad++;
                $display("FAIL glitch_settle cyc%0d: got %b want %b", j, act[0], expv[0]);
            end
            if (j < 5 && !act[0][3]) drops++;
            if (act[0][1]) begin rcnt++; if (at < 0) at = j; end
        end
        n_cmp++;
        if (at != 5 || rcnt != 1 || drops != 0) begin
            n_bad++;
            $display("FAIL glitch_timing: release at %0d x%0d early drops %0d, want at 5 x1 drops 0", at, rcnt, drops);
        end
    endtask

    task automatic test_auto_repeat;
        int want [10] = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34};
        int got  [$];
        int at = -1, pcnt = 0;
        set_btn(1, 1'b1);
        for (int j = 0; j < 41; j++) begin
            @(negedge clk);
            n_cmp++;
            if (act[1] !== expv[1]) begin
                n_bad++;
                $display("FAIL repeat cyc%0d: got %b want %b", j, act[1], expv[1]);
            end
            if (act[1][2]) begin pcnt++; if (at < 0) at = j; end
            if (act[1][0] && at >= 0) got.push_back(j - at);
        end
        n_cmp++;
        if (pcnt != 1 || got.size() != 10) begin
            n_bad++;
            $display("FAIL repeat_count: press x%0d steps x%0d, want press x1 steps x10", pcnt, got.size());
        end else begin
            for (int s = 0; s < 10; s++) begin
                n_cmp++;
                if (got[s] != want[s]) begin
                    n_bad++;
                    $display("FAIL repeat_offset%0d: got %0d want %0d", s, got[s], want[s]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        int at = -1;
        set_btn(0, 1'b1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (act[i] !== 4'b0000) begin
                n_bad++;
                $display("FAIL mid_reset dut%0d: got %b want 0000", i, act[i]);
            end
        end
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_cmp++;
            if (act[0] !== expv[0]) begin
                n_bad++;
                $display("FAIL mid_reset_recover cyc%0d: got %b want %b", j, act[0], expv[0]);
            end
            if (act[0][2] && at < 0) at = j;
        end
        n_cmp++;
        if (at != 5) begin
            n_bad++;
            $display("FAIL mid_reset_timing: press at %0d, want 5", at);
        end
    endtask

    task automatic test_single_cycle;
        int pat = -1, rat = -1;
        set_btn(2, 1'b0);
        repeat (5) @(negedge clk);
        set_btn(2, 1'b1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_cmp++;
            if (act[2] !== expv[2]) begin
                n_bad++;
                $display("FAIL single_cycle cyc%0d: got %b want %b", j, act[2], expv[2]);
            end
            if (act[2][2] && pat < 0) pat = j;
            if (act[2][1] && rat < 0) rat = j;
            if (j == 0) set_btn(2, 1'b0);
        end
        n_cmp++;
        if (pat != 2 || rat != 3) begin
            n_bad++;
            $display("FAIL single_cycle_timing: press at %0d release at %0d, want 2 and 3", pat, rat);
        end
    endtask

    task automatic test_random;
        int odds = 4;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (act[i] !== expv[i]) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc%0d: got %b want %b", i, c, act[i], expv[i]);
                end
            end
            if (c % 200 == 0) odds = int'($urandom_range(2, 40));
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, odds - 1) == 0) btn[i] = ~btn[i];
            rst_n = ($urandom_range(0, 599) != 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_auto_repeat();
        test_reset_mid_hold();
        test_single_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cr16_button_debounce.md
Name: cr16_button_debounce

Overview:
- Conditions one raw board pushbutton into clean, synchronous step events for the CR16 board-level front ends.
- Its primary consumer is the step/advance input of the ALU bring-up top, which loads operands and opcode one press at a time.
- Contains a 2-flop synchronizer, a debounce FSM with a stability counter, and an optional hold-to-auto-repeat generator.
- All outputs are registered in the I_CLK domain.

Parameters:
- P_DEBOUNCE_CYCLES, 1000000: consecutive synchronized samples required to accept a level change (20 ms at 50 MHz); must be >= 1.
- P_ACTIVE_LOW, 1: 1 means the raw button reads 0 when pressed; 0 means it reads 1 when pressed.
- P_REPEAT_DELAY, 0: HELD cycles before the first auto-repeat; 0 disables auto-repeat.
- P_REPEAT_PERIOD, 1: cycles between subsequent auto-repeats; must be >= 1 when P_REPEAT_DELAY > 0.

Ports:
- I_CLK  input  1  system clock; single clock domain.
- I_RST  input  1  reset, synchronous, active-low.
- I_BUTTON  input  1  raw asynchronous pushbutton level.
- O_LEVEL  output  1  debounced pressed level; 1 = pressed.
- O_PRESS  output  1  one-cycle pulse on accepted press.
- O_RELEASE  output  1  one-cycle pulse on accepted release.
- O_STEP  output  1  one-cycle pulse on accepted press and on every auto-repeat.

Behaviour:
- Reset (I_RST=0 at a rising I_CLK edge):
  - Both synchronizer flops load the released raw level (P_ACTIVE_LOW ? 1 : 0).
  - FSM goes to IDLE; both counters are cleared.
  - All outputs are 0.
  - Reset mid-operation aborts the current state immediately. A button still held after reset deasserts is debounced as a new press.
- Synchronizer: two flops sampling I_BUTTON. p = normalized synchronized pressed (second flop XOR P_ACTIVE_LOW inverted accordingly). The FSM uses only p.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: p=1 -> PRESS_WAIT with dcnt=1. Exception: if P_DEBOUNCE_CYCLES=1, go directly to HELD with the accept actions below.
  - PRESS_WAIT, p=0: -> IDLE, dcnt=0 (bounce rejected, no output).
  - PRESS_WAIT, p=1 and dcnt=P_DEBOUNCE_CYCLES-1: -> HELD. On that same edge O_LEVEL<=1, O_PRESS<=1, O_STEP<=1, rcnt<=0, repeated<=0.
  - PRESS_WAIT, p=1 otherwise: dcnt++.
  - HELD, p=0: -> RELEASE_WAIT with dcnt=1. Exception: if P_DEBOUNCE_CYCLES=1, accept the release immediately.
  - HELD, p=1: auto-repeat logic runs.
  - RELEASE_WAIT, p=1: -> HELD, dcnt=0. O_LEVEL stays 1; no pulses.
  - RELEASE_WAIT, p=0, N-th consecutive observation: -> IDLE. O_LEVEL<=0, O_RELEASE<=1.
- Latency: with N = P_DEBOUNCE_CYCLES, if the edge that first captures a changed raw level is edge k, the output change and pulse are registered at edge k+N+1.
- Auto-repeat (only when P_REPEAT_DELAY>0; counts only while in HELD with p=1):
  - rcnt increments each such cycle.
  - When repeated=0 and rcnt reaches P_REPEAT_DELAY: O_STEP pulses, rcnt<=0, repeated<=1.
  - When repeated=1 and rcnt reaches P_REPEAT_PERIOD: O_STEP pulses, rcnt<=0.
  - rcnt is frozen in RELEASE_WAIT and resumes on return to HELD.
  - O_PRESS never pulses for repeats.
- Pulse rules:
  - All pulses last exactly one cycle.
  - O_PRESS and O_RELEASE are never high together.
  - O_STEP is a superset of O_PRESS.
- Counters: width $clog2 of (max parameter + 1). Counters saturate-free: they always clear on a transition, so wrap-around never occurs.

Test Plan:
1. N=4, repeat off. After reset, hold I_BUTTON=0 (active-low press) stable. -> O_LEVEL rises at edge k+5; O_PRESS and O_STEP high exactly that one cycle; O_RELEASE=0.
2. N=4. Press with bounce 0,1,0,1 on alternate cycles, then stable 0. -> no pulse during bounce; single O_PRESS at 5 edges after the stable-0 capture edge; exactly one pulse total.
3. N=4, pressed. Release with a 2-cycle glitch back to pressed in RELEASE_WAIT, then stable release. -> O_LEVEL stays 1 through the glitch; one O_RELEASE at 5 edges after the final release capture edge.
4. N=4, P_REPEAT_DELAY=10, P_REPEAT_PERIOD=3. Hold for 30 cycles after acceptance. -> O_STEP at acceptance cycle, +10, +13, +16, ...; O_PRESS only once.
5. Assert I_RST=0 for one cycle while in HELD with I_BUTTON still pressed. -> all outputs 0 the next cycle, state IDLE; then a fresh O_PRESS N+1 edges after reset deasserts plus synchronizer refill.
6. P_DEBOUNCE_CYCLES=1, P_ACTIVE_LOW=0. Pulse I_BUTTON=1 for one cycle. -> O_PRESS at the 2nd edge after capture; O_RELEASE one cycle later.
